// File: rtl/t05_arb_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
// Optional timeout feature is enabled in the top with macro T05_ARB_TIMEOUT_EN.
package t05_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int MAX_WORDS = 4;

  // Requester indices on the req/grant/done vectors
  localparam int REQ_HIST  = 0;
  localparam int REQ_FLV   = 1;
  localparam int REQ_HTREE = 2;
  localparam int REQ_CB    = 3;
  localparam int REQ_TRN   = 4;

  // SRAM region bases used by the pipeline stages
  localparam logic [31:0] HIST_BASE  = 32'd0;
  localparam logic [31:0] HTREE_BASE = 32'd1024;
  localparam logic [31:0] CB_BASE    = 32'd2048;

  // Word counts above MAX_WORDS are clamped rather than rejected
  function automatic logic [2:0] clamp_nwords(input logic [2:0] n);
    return (n > 3'(MAX_WORDS)) ? 3'(MAX_WORDS) : n;
  endfunction

endpackage

// File: rtl/t05_rr_picker.sv
// Combinational round-robin winner select: searches upward from last+1 with wrap.
module t05_rr_picker #(
  parameter int NREQ = 5,
  parameter int IW   = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [IW-1:0] cand;

  // First requesting index after the previous winner wins
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    cand   = '0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = IW'((int'(last) + off) % NREQ);
      if (!valid && req[cand]) begin
        winner[cand] = 1'b1;
        valid        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/t05_sram_arbiter.sv
// Round-robin arbiter sharing one 32-bit wishbone SRAM port between NREQ
// requesters, each posting a transaction of up to 4 words.
// Optional feature: T05_ARB_TIMEOUT_EN bounds busy WAIT cycles per word.
//
// Handshake: a requester raises req (level) with its we/addr/nwords/wdata
// stable; fields are sampled in the cycle its grant is decided. grant stays
// high for the whole transaction; done pulses for one cycle (with grant still
// high) and the requester may drop req from then on. Dropping req earlier is
// ignored. Each bus word is one ISSUE strobe cycle followed by WAIT cycles
// until busy_o is seen low.
module t05_sram_arbiter
  import t05_arb_pkg::*;
#(
  parameter int NREQ    = 5,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*32-1:0]   req_addr,
  input  logic [NREQ*3-1:0]    req_nwords,
  input  logic [NREQ*128-1:0]  req_wdata,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic [127:0]         rdata,
  output logic                 err,
  output logic                 wr_en,
  output logic                 r_en,
  input  logic                 busy_o,
  output logic [3:0]           select,
  output logic [31:0]          addr,
  output logic [31:0]          data_i,
  input  logic [31:0]          data_o,
  output arb_state_t           arb_state
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t       state_q, state_d;
  logic [NREQ-1:0]  win_oh;
  logic             win_valid;
  logic [IW-1:0]    win_idx;
  logic [2:0]       win_nwords;
  logic [IW-1:0]    last_q;
  logic [NREQ-1:0]  grant_q;
  logic             we_q;
  logic [31:0]      base_q;
  logic [2:0]       nwords_q;
  logic [2:0]       idx_q;
  logic [127:0]     wdata_q;
  logic [127:0]     rdata_q;
  logic             word_done;
  logic             last_word;
  logic             tout_hit;

  t05_rr_picker #(.NREQ(NREQ), .IW(IW)) u_picker (
    .req    (req),
    .last   (last_q),
    .winner (win_oh),
    .valid  (win_valid)
  );

  // Convert the one-hot winner to an index and fetch its clamped word count
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_oh[i]) win_idx = i[IW-1:0];
    end
    win_nwords = clamp_nwords(req_nwords[win_idx*3 +: 3]);
  end

  assign word_done = (state_q == WAIT) && !busy_o;
  assign last_word = ((idx_q + 3'd1) == nwords_q);

`ifdef T05_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt_q;
  logic          err_q;

  assign tout_hit = (state_q == WAIT) && busy_o && (tcnt_q == TW'(TIMEOUT - 1));
  assign err      = (state_q == DONE) && err_q;

  // Busy-cycle counter per word; err flag remembers an abandoned transaction
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == ISSUE) tcnt_q <= '0;
      else if ((state_q == WAIT) && busy_o) tcnt_q <= tcnt_q + TW'(1);
      if ((state_q == IDLE) && win_valid) err_q <= 1'b0;
      else if (tout_hit) err_q <= 1'b1;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
  assign tout_hit       = 1'b0;
  assign err            = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (win_valid) state_d = (win_nwords == 3'd0) ? DONE : ISSUE;
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (word_done)     state_d = last_word ? DONE : ISSUE;
        else if (tout_hit) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction context: latched at grant, word index and read buffer per word
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      last_q   <= IW'(NREQ - 1);
      grant_q  <= '0;
      we_q     <= 1'b0;
      base_q   <= '0;
      nwords_q <= '0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if ((state_q == IDLE) && win_valid) begin
        grant_q  <= win_oh;
        last_q   <= win_idx;
        we_q     <= req_we[win_idx];
        base_q   <= req_addr[win_idx*32 +: 32];
        nwords_q <= win_nwords;
        wdata_q  <= req_wdata[win_idx*128 +: 128];
        rdata_q  <= '0;
        idx_q    <= '0;
      end
      if (state_q == DONE) grant_q <= '0;
      if (word_done) begin
        if (!we_q) rdata_q[idx_q[1:0]*32 +: 32] <= data_o;
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  // Bus and requester outputs decoded from state and latched context
  always_comb begin
    wr_en     = (state_q == ISSUE) && we_q;
    r_en      = (state_q == ISSUE) && !we_q;
    addr      = base_q + {27'd0, idx_q, 2'b00};
    data_i    = we_q ? wdata_q[idx_q[1:0]*32 +: 32] : 32'd0;
    select    = 4'b1111;
    grant     = grant_q;
    done      = (state_q == DONE) ? grant_q : '0;
    rdata     = rdata_q;
    arb_state = state_q;
  end

endmodule

// File: tb/tb_t05_sram_arbiter.sv
// Self-checking bench for t05_sram_arbiter: scoreboarded bus accesses and
// done/rdata results, plus grant-length and round-robin order checks.
module tb_t05_sram_arbiter;
  import t05_arb_pkg::*;

  localparam int NREQ = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]     req = '0;
  logic [NREQ-1:0]     req_we = '0;
  logic [NREQ*32-1:0]  req_addr = '0;
  logic [NREQ*3-1:0]   req_nwords = '0;
  logic [NREQ*128-1:0] req_wdata = '0;
  logic [NREQ-1:0]     grant, done;
  logic [127:0]        rdata;
  logic                err, wr_en, r_en;
  logic                busy_o = 1'b0;
  logic [3:0]          select;
  logic [31:0]         addr, data_i;
  logic [31:0]         data_o = '0;
  arb_state_t          arb_state;

  t05_sram_arbiter #(.NREQ(NREQ), .TIMEOUT(8)) dut (
    .clk(clk), .nrst(nrst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_nwords(req_nwords), .req_wdata(req_wdata), .grant(grant), .done(done),
    .rdata(rdata), .err(err), .wr_en(wr_en), .r_en(r_en), .busy_o(busy_o),
    .select(select), .addr(addr), .data_i(data_i), .data_o(data_o),
    .arb_state(arb_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [64:0]  exp_acc_q[$];   // {we, addr, data_i}
  logic [131:0] exp_done_q[$];  // {idx, err, rdata}
  int bus_lat = 0;
  int bcnt = 0;
  int glen_cur = 0;
  int last_glen = 0;
  int onehot_viol = 0;

  task automatic check(input string tag, input logic [131:0] got, input logic [131:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Read data returned by the bus stub for a given address
  function automatic logic [31:0] rd_model(input logic [31:0] a);
    case (a)
      32'h10:  return 32'h11;
      32'h14:  return 32'h22;
      32'h18:  return 32'h33;
      32'h1C:  return 32'h44;
      default: return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  task automatic push_exp(input int idx, input logic we, input logic [31:0] a,
                          input logic [2:0] nw, input logic [127:0] wd);
    int n;
    logic [127:0] rd;
    logic [31:0] aa;
    n  = (nw > 3'd4) ? 4 : int'(nw);
    rd = '0;
    for (int k = 0; k < n; k++) begin
      aa = a + 32'(4 * k);
      exp_acc_q.push_back({we, aa, we ? wd[k*32 +: 32] : 32'h0});
      if (!we) rd[k*32 +: 32] = rd_model(aa);
    end
    exp_done_q.push_back({3'(idx), 1'b0, rd});
  endtask

  // ---------------- monitor + bus stub (negedge) ----------------
  always @(negedge clk) begin
    if (nrst) begin
      if (grant != '0 && !$onehot(grant)) onehot_viol++;
      if (grant != '0) glen_cur++;
      if (wr_en || r_en) begin
        if (exp_acc_q.size() == 0) check("acc_unexpected", {wr_en, addr, data_i}, '0);
        else check("bus_access", {wr_en, addr, data_i}, exp_acc_q.pop_front());
        bcnt   = bus_lat;
        busy_o = (bus_lat > 0);
        data_o = r_en ? rd_model(addr) : 32'h0;
      end else if (arb_state == WAIT) begin
        busy_o = (bcnt > 0);
        if (bcnt > 0) bcnt--;
      end
      if (done != '0) begin
        logic [2:0] didx;
        didx = '0;
        for (int i = 0; i < NREQ; i++) if (done[i]) didx = 3'(i);
        if (!$onehot(done)) onehot_viol++;
        last_glen = glen_cur;
        if (exp_done_q.size() == 0) check("done_unexpected", {didx, err, rdata}, '0);
        else check("done_result", {didx, err, rdata}, exp_done_q.pop_front());
      end
      if (grant == '0) glen_cur = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    nrst = 1'b0;
    req  = '0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic set_fields(input int idx, input logic we, input logic [31:0] a,
                            input logic [2:0] nw, input logic [127:0] wd);
    req_we[idx]              = we;
    req_addr[idx*32 +: 32]   = a;
    req_nwords[idx*3 +: 3]   = nw;
    req_wdata[idx*128 +: 128] = wd;
  endtask

  task automatic wait_any_done(output int didx);
    int cyc;
    cyc  = 0;
    didx = -1;
    while (done == '0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (done == '0) check("done_wait_timeout", 132'd0, 132'd1);
    else for (int i = 0; i < NREQ; i++) if (done[i]) didx = i;
  endtask

  task automatic do_txn(input int idx, input logic we, input logic [31:0] a,
                        input logic [2:0] nw, input logic [127:0] wd, input int lat);
    int didx;
    bus_lat = lat;
    set_fields(idx, we, a, nw, wd);
    push_exp(idx, we, a, nw, wd);
    @(negedge clk);
    req[idx] = 1'b1;
    @(negedge clk);
    wait_any_done(didx);
    req[idx] = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int didx;
    int cnt;
    logic seen0;
    logic [127:0] wd;

    // Reset values
    #2;
    check("rst_grant", grant, '0);
    check("rst_done", done, '0);
    check("rst_strobes", {wr_en, r_en, err}, 3'b000);
    check("rst_select", select, 4'b1111);
    check("rst_addr_data", {addr, data_i}, 64'd0);
    check("rst_rdata", rdata, 128'd0);
    check("rst_state", arb_state, IDLE);
    apply_reset();

    // Single write to the htree region, busy 3 cycles per word
    wd = {64'd0, 32'hBBBB_0002, 32'hAAAA_0001};
    do_txn(REQ_HTREE, 1'b1, HTREE_BASE, 3'd2, wd, 3);
    check("wr_grant_len", 32'(last_glen), 32'd11);

    // 4-word read
    do_txn(REQ_TRN, 1'b0, 32'h10, 3'd4, '0, int'($urandom_range(0, 2)));
    check("rd4_rdata", rdata, 128'h00000044_00000033_00000022_00000011);

    // 1-word read with bus idle: ISSUE, WAIT, DONE
    do_txn(REQ_HIST, 1'b0, HIST_BASE, 3'd1, '0, 0);
    check("rd1_grant_len", 32'(last_glen), 32'd3);

    // nwords = 0: no bus access, done in the grant cycle
    do_txn(REQ_FLV, 1'b0, CB_BASE, 3'd0, '0, 0);
    check("nw0_grant_len", 32'(last_glen), 32'd1);
    check("nw0_rdata", rdata, 128'd0);

    // nwords = 7 clamps to 4 accesses
    wd = {$urandom, $urandom, $urandom, $urandom};
    do_txn(REQ_CB, 1'b1, CB_BASE, 3'd7, wd, 1);

    // Reset during WAIT of word 2 of a 3-word read
    bus_lat = 3;
    set_fields(REQ_CB, 1'b0, 32'h200, 3'd3, '0);
    exp_acc_q.push_back({1'b0, 32'h200, 32'h0});
    exp_acc_q.push_back({1'b0, 32'h204, 32'h0});
    @(negedge clk);
    req[REQ_CB] = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 2; c++) begin
      @(negedge clk);
      if (r_en) cnt++;
    end
    check("rst_mid_strobes_seen", 32'(cnt), 32'd2);
    @(negedge clk);
    check("rst_mid_in_wait", arb_state, WAIT);
    #2 nrst = 1'b0;
    #1;
    check("rst_mid_outputs", {grant, done, wr_en, r_en, err}, '0);
    check("rst_mid_state", arb_state, IDLE);
    check("rst_mid_rdata", rdata, 128'd0);
    @(negedge clk);
    req  = '0;
    nrst = 1'b1;

    // After reset, req1 and req4 together: req1 first
    bus_lat = 0;
    set_fields(REQ_FLV, 1'b0, 32'h40, 3'd1, '0);
    set_fields(REQ_TRN, 1'b0, 32'h80, 3'd2, '0);
    push_exp(REQ_FLV, 1'b0, 32'h40, 3'd1, '0);
    push_exp(REQ_TRN, 1'b0, 32'h80, 3'd2, '0);
    req = 5'b10010;
    @(negedge clk);
    @(negedge clk);
    check("post_rst_first_grant", grant, 5'b00010);
    for (int k = 0; k < 2; k++) begin
      wait_any_done(didx);
      if (didx >= 0) req[didx] = 1'b0;
      @(negedge clk);
    end

    // Contention after reset: order 0,1,2,3,4,0
    apply_reset();
    bus_lat = 1;
    for (int i = 0; i < NREQ; i++) begin
      set_fields(i, 1'($urandom_range(0, 1)), 32'($urandom) & 32'hFFFF_FFFC,
                 3'($urandom_range(1, 2)), {$urandom, $urandom, $urandom, $urandom});
    end
    for (int k = 0; k < 6; k++) begin
      int i;
      i = k % NREQ;
      push_exp(i, req_we[i], req_addr[i*32 +: 32], req_nwords[i*3 +: 3], req_wdata[i*128 +: 128]);
    end
    req   = 5'b11111;
    seen0 = 1'b0;
    for (int k = 0; k < 6; k++) begin
      wait_any_done(didx);
      check("rr_order", 32'(didx), 32'(k % NREQ));
      if (didx == 0 && !seen0) seen0 = 1'b1;
      else if (didx >= 0) req[didx] = 1'b0;
      @(negedge clk);
    end
    req = '0;
    @(negedge clk);

    // Random sequential transactions
    for (int t = 0; t < 10; t++) begin
      do_txn(int'($urandom_range(0, NREQ - 1)), 1'($urandom_range(0, 1)), 32'($urandom),
             3'($urandom_range(0, 7)), {$urandom, $urandom, $urandom, $urandom},
             int'($urandom_range(0, 3)));
    end

`ifdef T05_ARB_TIMEOUT_EN
    // Bus stuck busy: abandon after 8 busy WAIT cycles with err
    bus_lat = 1000;
    set_fields(REQ_HTREE, 1'b0, 32'h300, 3'd2, '0);
    exp_acc_q.push_back({1'b0, 32'h300, 32'h0});
    exp_done_q.push_back({3'(REQ_HTREE), 1'b1, 128'd0});
    @(negedge clk);
    req[REQ_HTREE] = 1'b1;
    @(negedge clk);
    wait_any_done(didx);
    req[REQ_HTREE] = 1'b0;
    check("tout_grant_len", 32'(last_glen), 32'd10);
    @(negedge clk);
    check("tout_back_idle", arb_state, IDLE);
    bus_lat = 0;
    repeat (2) @(negedge clk);
    busy_o = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("acc_queue_empty", 32'(exp_acc_q.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done_q.size()), 32'd0);
    check("onehot_grant_done", 32'(onehot_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
